// File: rtl/serial_tx_piso.sv
// Framed PISO transmitter: start bit, WIDTH data bits MSB first, stop bit, each held DIV clocks.
// Define PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module serial_tx_piso #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             load_ready,
  output logic             sout,
  output logic             busy,
  output logic             frame_done
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    div_cnt_q, div_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             accept, bit_end;
`ifdef PARITY_EN
  logic             par_q, par_d;
  logic             buf_par_q, buf_par_d;
`endif

  assign load_ready = !buf_full_q;
  assign sout       = sout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
`ifdef PARITY_EN
    par_d      = par_q;
    buf_par_d  = buf_par_q;
`endif
    accept  = load && !buf_full_q;
    bit_end = (div_cnt_q == DIV_LAST);

    if (state_q != IDLE) div_cnt_d = bit_end ? '0 : div_cnt_q + 1'b1;

    if (accept && state_q != IDLE) begin
      buf_d      = din;
      buf_full_d = 1'b1;
`ifdef PARITY_EN
      buf_par_d  = ^din;
`endif
    end

    case (state_q)
      IDLE: if (accept) begin
        shift_d   = din;
`ifdef PARITY_EN
        par_d     = ^din;
`endif
        div_cnt_d = '0;
        state_d   = START;
      end
      START: if (bit_end) begin
        bit_cnt_d = '0;
        state_d   = DATA;
      end
      DATA: if (bit_end) begin
        shift_d = shift_q << 1;
        if (bit_cnt_q == BIT_LAST) begin
`ifdef PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
`ifdef PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) begin
        // Buffered word wins; a same-cycle load can only land here when the buffer is empty.
        if (buf_full_q) begin
          shift_d    = buf_q;
`ifdef PARITY_EN
          par_d      = buf_par_q;
`endif
          buf_full_d = 1'b0;
          state_d    = START;
        end else if (accept) begin
          shift_d    = din;
`ifdef PARITY_EN
          par_d      = ^din;
`endif
          buf_full_d = 1'b0;
          state_d    = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the state they describe.
    case (state_d)
      START:   sout_d = 1'b0;
      DATA:    sout_d = shift_d[WIDTH-1];
`ifdef PARITY_EN
      PARITY:  sout_d = par_d;
`endif
      default: sout_d = 1'b1;
    endcase
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == STOP) && (div_cnt_d == DIV_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      sout_q       <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PARITY_EN
      par_q        <= 1'b0;
      buf_par_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      sout_q       <= sout_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef PARITY_EN
      par_q        <= par_d;
      buf_par_q    <= buf_par_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_tx_piso.sv
// Directed bench for serial_tx_piso: table of single frames plus back-to-back, late load,
// mid-frame reset and a DIV=1/WIDTH=4 instance.
module tb_serial_tx_piso;
  localparam int W = 8;
  localparam int D = 4;
`ifdef PARITY_EN
  localparam int PB = 1;
  localparam int F1 = 7;
  localparam logic [6:0] SEQ1 = 7'b0100101;
`else
  localparam int PB = 0;
  localparam int F1 = 6;
  localparam logic [6:0] SEQ1 = 7'b0010011;
`endif
  localparam int F = (W + 2 + PB) * D;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       load, load_ready, sout, busy, frame_done;
  logic [3:0] din1;
  logic       load1, load_ready1, sout1, busy1, frame_done1;

  always #5 clk = ~clk;

  serial_tx_piso #(.WIDTH(W), .DIV(D)) u_dut (
    .clk(clk), .reset(reset), .din(din), .load(load), .load_ready(load_ready),
    .sout(sout), .busy(busy), .frame_done(frame_done));

  serial_tx_piso #(.WIDTH(4), .DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .din(din1), .load(load1), .load_ready(load_ready1),
    .sout(sout1), .busy(busy1), .frame_done(frame_done1));

  // ser: sout bit per bit-time in order (start, d7..d0, stop); par: even parity of din.
  typedef struct {
    logic [7:0] din;
    logic [9:0] ser;
    logic       par;
  } vec_t;
  vec_t tbl[8];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input vec_t v, input int k);
    int b = k / D;
    if (b <= W) return v.ser[9-b];
    if (PB == 1 && b == W + 1) return v.par;
    return 1'b1;
  endfunction

  task automatic start_idle(input logic [7:0] d);
    @(negedge clk);
    load = 1'b1;
    din  = d;
    @(posedge clk);
  endtask

  // Called just after the accepting edge; returns at the negedge of the frame's last cycle.
  task automatic check_frame(input vec_t v, input int inj_at, input logic [7:0] inj_din,
                             input int lr_lo_from, input int lr_lo_to);
    for (int k = 0; k < F; k++) begin
      @(negedge clk);
      chk($sformatf("sout %02h k=%0d", v.din, k), sout, exp_bit(v, k));
      chk($sformatf("busy %02h k=%0d", v.din, k), busy, 1'b1);
      chk($sformatf("frame_done %02h k=%0d", v.din, k), frame_done, k == F - 1);
      chk($sformatf("load_ready %02h k=%0d", v.din, k), load_ready,
          !(k >= lr_lo_from && k <= lr_lo_to));
      if (k == inj_at) begin
        load = 1'b1;
        din  = inj_din;
      end else begin
        load = 1'b0;
        din  = 8'($urandom);
      end
      if (k < F - 1) @(posedge clk);
    end
  endtask

  task automatic check_idle(input string nm);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    chk({nm, " idle busy"}, busy, 1'b0);
    chk({nm, " idle sout"}, sout, 1'b1);
    chk({nm, " idle frame_done"}, frame_done, 1'b0);
    chk({nm, " idle load_ready"}, load_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hA5, 10'b0101001011, 1'b0};
    tbl[1] = '{8'h3C, 10'b0001111001, 1'b0};
    tbl[2] = '{8'hC3, 10'b0110000111, 1'b0};
    tbl[3] = '{8'h01, 10'b0000000011, 1'b1};
    tbl[4] = '{8'hFF, 10'b0111111111, 1'b0};
    tbl[5] = '{8'h80, 10'b0100000001, 1'b1};
    tbl[6] = '{8'h07, 10'b0000001111, 1'b1};
    tbl[7] = '{8'h00, 10'b0000000001, 1'b0};

    // Reset with loads held high: loads must be dropped.
    reset = 1'b1; load = 1'b1; din = 8'hA5; load1 = 1'b1; din1 = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst sout", sout, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst frame_done", frame_done, 1'b0);
    chk("rst load_ready", load_ready, 1'b1);
    chk("rst sout1", sout1, 1'b1);
    chk("rst busy1", busy1, 1'b0);
    reset = 1'b0; load = 1'b0; load1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("post-rst busy", busy, 1'b0);
    chk("post-rst busy1", busy1, 1'b0);

    // Single frames from idle; din scrambled after acceptance.
    for (int i = 0; i < 8; i++) begin
      start_idle(tbl[i].din);
      check_frame(tbl[i], -1, 8'h00, -1, -1);
      check_idle($sformatf("tbl%0d", i));
    end

    // Back-to-back: second word buffered at cycle 5, no gap between frames.
    start_idle(8'h3C);
    check_frame(tbl[1], 5, 8'hC3, 6, F - 1);
    @(posedge clk);
    check_frame(tbl[2], -1, 8'h00, -1, -1);
    check_idle("b2b");

    // Load on the final stop cycle with an empty buffer.
    start_idle(8'hA5);
    check_frame(tbl[0], F - 1, 8'h01, -1, -1);
    @(posedge clk);
    check_frame(tbl[3], -1, 8'h00, -1, -1);
    check_idle("late");

    // Reset mid-frame with a word sitting in the buffer.
    start_idle(8'hFF);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      chk($sformatf("abort sout k=%0d", k), sout, exp_bit(tbl[4], k));
      load = (k == 5);
      din  = 8'h5A;
      if (k < 16) @(posedge clk);
    end
    chk("abort load_ready full", load_ready, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort sout", sout, 1'b1);
    chk("abort busy", busy, 1'b0);
    chk("abort load_ready", load_ready, 1'b1);
    chk("abort frame_done", frame_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < F; k++) begin
      @(negedge clk);
      chk($sformatf("abort quiet busy k=%0d", k), busy, 1'b0);
      chk($sformatf("abort quiet frame_done k=%0d", k), frame_done, 1'b0);
    end
    start_idle(8'h80);
    check_frame(tbl[5], -1, 8'h00, -1, -1);
    check_idle("after-abort");

    // DIV=1, WIDTH=4 instance.
    @(negedge clk);
    load1 = 1'b1;
    din1  = 4'b1001;
    @(posedge clk);
    for (int k = 0; k < F1; k++) begin
      @(negedge clk);
      chk($sformatf("div1 sout k=%0d", k), sout1, SEQ1[F1-1-k]);
      chk($sformatf("div1 busy k=%0d", k), busy1, 1'b1);
      chk($sformatf("div1 frame_done k=%0d", k), frame_done1, k == F1 - 1);
      load1 = 1'b0;
      din1  = 4'($urandom);
      if (k < F1 - 1) @(posedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    chk("div1 idle busy", busy1, 1'b0);
    chk("div1 idle sout", sout1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
